wb_port_arbiter: RTL
====================

Name: wb_port_arbiter

Overview:
Owns the single register-file write port after the write-back stage. It merges two requesters:
- the in-order pipeline write-back, whose data is selected between memory and ALU by select_wb;
- a long-latency unit (LLU, e.g. multiplier/divider) that returns results out of band.

LLU results go into a small FIFO and drain into idle write-port slots. A starvation counter forces a one-cycle pipeline stall so a waiting LLU result can drain.

Parameters:
- N, 32, data width of the register file.
- ADDR_W, 5, register address width (32 DLX registers).
- DEPTH, 2, LLU result FIFO entries; must be a power of 2 and ≥2.
- MAX_WAIT, 4, cycles an LLU head entry may lose to the pipeline before a forced drain; must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- pipe_wb_valid  in  1  pipeline WB instruction writes the RF this cycle.
- pipe_wb_addr  in  ADDR_W  destination register of the pipeline WB.
- select_wb  in  1  0 = data_from_memory, 1 = data_from_alu.
- data_from_memory  in  N  load data.
- data_from_alu  in  N  ALU result.
- llu_valid  in  1  LLU result offered.
- llu_ready  out  1  arbiter accepts the LLU result (FIFO not full).
- llu_addr  in  ADDR_W  LLU destination register.
- llu_data  in  N  LLU result.
- rf_we  out  1  RF write enable (registered).
- rf_waddr  out  ADDR_W  RF write address (registered).
- rf_wdata  out  N  RF write data (registered).
- stall_pipe  out  1  freeze the pipeline this cycle.
- pending_cnt  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async, rst=1): FIFO empty and pointers 0, wait counter 0, state IDLE. Outputs: rf_we=0, rf_waddr=0, rf_wdata=0, stall_pipe=0, pending_cnt=0, llu_ready=1.
- Latency: the winning request appears on rf_* one cycle after it is sampled. Outputs are registered.
- LLU handshake:
  - A transfer occurs on a rising edge with llu_valid & llu_ready.
  - llu_ready = !full, combinational from registered occupancy.
  - The LLU holds addr and data stable while valid and not ready.
- Pipeline data select: pipe data = select_wb ? data_from_alu : data_from_memory.
- State machine:
  - IDLE: FIFO empty.
    - A pipeline request is written.
    - An LLU transfer with no pipeline request is written directly that cycle; the FIFO is bypassed and pending_cnt stays 0.
    - An LLU transfer that coincides with a pipeline request is pushed → PENDING.
  - PENDING: FIFO not empty.
    - pipe_wb_valid=1: pipeline wins and the wait counter increments.
    - pipe_wb_valid=0: head is popped and written, wait counter cleared; go to IDLE if the FIFO becomes empty.
    - Wait counter reaching MAX_WAIT-1 while the pipeline wins → FORCE_DRAIN next cycle.
  - FORCE_DRAIN: lasts exactly one cycle.
    - stall_pipe=1 combinationally from state; pipe_wb_valid is ignored, and the pipeline re-presents that instruction next cycle.
    - Head is popped and written; wait counter cleared.
    - Next state is PENDING if entries remain, else IDLE.
- Simultaneous push and pop: occupancy unchanged. A push into a full FIFO cannot occur because llu_ready=0.
- Register 0: any write with address 0, from either source, is consumed normally but drives rf_we=0.
- Pointers wrap modulo DEPTH. pending_cnt ranges from 0 to DEPTH.
- Reset mid-operation: pending LLU entries are discarded, and the LLU must reissue.

Optional Feature:
WB_WAW_SQUASH_EN
- Defined: when a pipeline write to address A wins, every FIFO entry with address A (A≠0) is invalidated. Invalid entries are popped without asserting rf_we, so an older LLU result cannot overwrite a younger pipeline value.
- Undefined: no address comparison. The FIFO drains in order regardless, and the compiler or scheduler guarantees no WAW conflict.

Decomposition:
- Shared package dlx_pkg:
  - wb_state_t enum (IDLE, PENDING, FORCE_DRAIN);
  - rf_wr_req_t struct {valid, addr, data};
  - constant RF_ZERO_ADDR.
- One natural sub-module: wb_llu_fifo, a parameterised DEPTH×(ADDR_W+N) FIFO with push, pop, full, empty, count and, under the macro, a per-entry valid clear.

Test Plan:
1. Pipeline only: pipe_wb_valid=1, addr=5, select_wb=0, mem=0x0000_0000, alu=0xFFFF_FFFF → next cycle rf_we=1, waddr=5, wdata=0x0. Repeat with select_wb=1 → wdata=0xFFFF_FFFF.
2. LLU only in IDLE: llu_valid=1, addr=7, data=0x1234_5678 → llu_ready=1 and next cycle rf_we=1, waddr=7, wdata=0x1234_5678, with pending_cnt=0 throughout.
3. Collision then fill:
   - Pipeline valid every cycle while the LLU offers 0xA and 0xB to addresses 8 and 9 → pending_cnt=2 and llu_ready=0.
   - A third LLU result is held until a slot frees.
4. Starvation: MAX_WAIT=4 with continuous pipeline writes and one pending entry → stall_pipe=1 exactly one cycle on the 5th cycle, rf_waddr=8 written, and the pipeline write is re-presented and written the cycle after.
5. Register 0: pipeline addr=0 and an LLU entry with addr=0 → rf_we stays 0 for both, and the FIFO pops normally.
6. Reset mid-operation: assert rst asynchronously with pending_cnt=2 → all outputs 0 immediately, llu_ready=1, and no write after release. Under WB_WAW_SQUASH_EN, a pending addr 9 followed by a pipeline write to 9 → the LLU entry drains with rf_we=0.

Source files
------------

// File: rtl/dlx_pkg.sv
// rtl/dlx_pkg.sv - shared write-back types for the DLX register-file write port
// Contents: wb_state_t arbiter states, rf_wr_req_t write request, RF_ZERO_ADDR.
// Optional build macro used by importers: WB_WAW_SQUASH_EN.
package dlx_pkg;

    localparam int DLX_N      = 32;
    localparam int DLX_ADDR_W = 5;

    // Writes to this register are consumed but never reach the register file.
    localparam logic [DLX_ADDR_W-1:0] RF_ZERO_ADDR = '0;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PENDING     = 2'd1,
        FORCE_DRAIN = 2'd2
    } wb_state_t;

    typedef struct packed {
        logic                  valid;
        logic [DLX_ADDR_W-1:0] addr;
        logic [DLX_N-1:0]      data;
    } rf_wr_req_t;

endpackage

// File: rtl/wb_llu_fifo.sv
// rtl/wb_llu_fifo.sv - DEPTH x (valid, addr, data) FIFO holding long-latency unit results
// Ports: clk, rst (async, high); push/push_addr/push_data write side; pop and
// head_valid/head_addr/head_data read side (head is combinational); full, empty, count.
// With WB_WAW_SQUASH_EN: clr_en/clr_addr invalidate every entry whose address matches.
module wb_llu_fifo #(
    parameter  int N      = 32,
    parameter  int ADDR_W = 5,
    parameter  int DEPTH  = 2,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [N-1:0]      push_data,
    input  logic              pop,
`ifdef WB_WAW_SQUASH_EN
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
`endif
    output logic              head_valid,
    output logic [ADDR_W-1:0] head_addr,
    output logic [N-1:0]      head_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              ent_valid [DEPTH];
    logic [ADDR_W-1:0] ent_addr  [DEPTH];
    logic [N-1:0]      ent_data  [DEPTH];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: only slots between rd_ptr and wr_ptr are ever read.
    // The clear comes first so an entry pushed in the same cycle keeps its valid bit.
    always_ff @(posedge clk) begin
`ifdef WB_WAW_SQUASH_EN
        if (clr_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_addr[i] == clr_addr) ent_valid[i] <= 1'b0;
            end
        end
`endif
        if (push) begin
            ent_valid[wr_ptr] <= 1'b1;
            ent_addr[wr_ptr]  <= push_addr;
            ent_data[wr_ptr]  <= push_data;
        end
    end

    assign head_valid = ent_valid[rd_ptr];
    assign head_addr  = ent_addr[rd_ptr];
    assign head_data  = ent_data[rd_ptr];
    assign full       = (cnt == CNT_W'(DEPTH));
    assign empty      = (cnt == '0);
    assign count      = cnt;

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - merges pipeline write-back and LLU results onto the single RF write port
// Ports: clk, rst (async, high); pipe_wb_valid/pipe_wb_addr/select_wb/data_from_memory/
// data_from_alu pipeline side; llu_valid/llu_ready/llu_addr/llu_data LLU side;
// rf_we/rf_waddr/rf_wdata registered write port; stall_pipe; pending_cnt FIFO occupancy.
// Optional build macro: WB_WAW_SQUASH_EN (pipeline writes invalidate queued LLU results to the same register).
module wb_port_arbiter
    import dlx_pkg::*;
#(
    // N and ADDR_W must match the package widths used by rf_wr_req_t.
    parameter  int N        = DLX_N,
    parameter  int ADDR_W   = DLX_ADDR_W,
    parameter  int DEPTH    = 2,
    parameter  int MAX_WAIT = 4,
    localparam int CNT_W    = $clog2(DEPTH) + 1,
    localparam int WAIT_W   = $clog2(MAX_WAIT) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_wb_valid,
    input  logic [ADDR_W-1:0] pipe_wb_addr,
    input  logic              select_wb,
    input  logic [N-1:0]      data_from_memory,
    input  logic [N-1:0]      data_from_alu,
    input  logic              llu_valid,
    output logic              llu_ready,
    input  logic [ADDR_W-1:0] llu_addr,
    input  logic [N-1:0]      llu_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [N-1:0]      rf_wdata,
    output logic              stall_pipe,
    output logic [CNT_W-1:0]  pending_cnt
);

    wb_state_t         state;
    logic [WAIT_W-1:0] wait_cnt;
    rf_wr_req_t        win;
    logic [N-1:0]      pipe_data;
    logic              llu_xfer;
    logic              bypass;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              head_valid;
    logic [ADDR_W-1:0] head_addr;
    logic [N-1:0]      head_data;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              drain_last;

    assign pipe_data  = select_wb ? data_from_alu : data_from_memory;
    assign llu_ready  = ~fifo_full;
    assign llu_xfer   = llu_valid & llu_ready;
    assign stall_pipe = (state == FORCE_DRAIN);
    assign fifo_push  = llu_xfer & ~bypass;
    // This pop empties the FIFO unless a new result arrives in the same cycle.
    assign drain_last = (fifo_cnt == CNT_W'(1)) & ~fifo_push;

    // Winner selection for the write port. In FORCE_DRAIN the pipeline request
    // is ignored; the stalled pipeline re-presents it next cycle.
    always_comb begin
        win      = '0;
        fifo_pop = 1'b0;
        bypass   = 1'b0;
        case (state)
            IDLE: begin
                if (pipe_wb_valid) begin
                    win = {1'b1, pipe_wb_addr, pipe_data};
                end else if (llu_xfer && fifo_empty) begin
                    bypass = 1'b1;
                    win    = {1'b1, llu_addr, llu_data};
                end
            end
            PENDING: begin
                if (pipe_wb_valid) begin
                    win = {1'b1, pipe_wb_addr, pipe_data};
                end else begin
                    fifo_pop = 1'b1;
                    win      = {head_valid, head_addr, head_data};
                end
            end
            FORCE_DRAIN: begin
                fifo_pop = 1'b1;
                win      = {head_valid, head_addr, head_data};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we    <= win.valid && (win.addr != ADDR_W'(RF_ZERO_ADDR));
            rf_waddr <= win.addr;
            rf_wdata <= win.data;
            case (state)
                IDLE: begin
                    if (fifo_push) state <= PENDING;
                end
                PENDING: begin
                    if (pipe_wb_valid) begin
                        // The head has now lost MAX_WAIT times: take the port next cycle.
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) state <= FORCE_DRAIN;
                    end else begin
                        wait_cnt <= '0;
                        if (drain_last) state <= IDLE;
                    end
                end
                FORCE_DRAIN: begin
                    wait_cnt <= '0;
                    state    <= drain_last ? IDLE : PENDING;
                end
                default: state <= IDLE;
            endcase
        end
    end

    wb_llu_fifo #(
        .N      (N),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_llu_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_addr  (llu_addr),
        .push_data  (llu_data),
        .pop        (fifo_pop),
`ifdef WB_WAW_SQUASH_EN
        .clr_en     (pipe_wb_valid && (state != FORCE_DRAIN) &&
                     (pipe_wb_addr != ADDR_W'(RF_ZERO_ADDR))),
        .clr_addr   (pipe_wb_addr),
`endif
        .head_valid (head_valid),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_cnt)
    );

    assign pending_cnt = fifo_cnt;

endmodule
